// File: rtl/i8080_pkg.sv
// Shared definitions for the 8080-style fetch sequencer: register and
// register-pair select codes, opcode constants, machine-cycle states and
// the instruction classes produced by the opcode decoder.
package i8080_pkg;

    // 8-bit register codes as they appear in the opcode d/s fields.
    localparam logic [2:0] REG_B = 3'b000;
    localparam logic [2:0] REG_C = 3'b001;
    localparam logic [2:0] REG_D = 3'b010;
    localparam logic [2:0] REG_E = 3'b011;
    localparam logic [2:0] REG_H = 3'b100;
    localparam logic [2:0] REG_L = 3'b101;
    localparam logic [2:0] REG_M = 3'b110;
    localparam logic [2:0] REG_A = 3'b111;

    // 16-bit address-latch source codes.
    localparam logic [2:0] RP_BC = 3'b000;
    localparam logic [2:0] RP_DE = 3'b001;
    localparam logic [2:0] RP_HL = 3'b010;
    localparam logic [2:0] RP_SP = 3'b011;
    localparam logic [2:0] RP_PC = 3'b100;

    // Opcodes handled by the sequencer.
    localparam logic [7:0] OPC_NOP = 8'h00;
    localparam logic [7:0] OPC_HLT = 8'h76;
    localparam logic [7:0] OPC_JMP = 8'hC3;
    localparam logic [1:0] OPC_MOV_GROUP = 2'b01;
    localparam logic [1:0] OPC_MVI_GROUP = 2'b00;

    // Machine-cycle states of the sequencer.
    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_F_T1   = 4'd1,
        ST_F_T2   = 4'd2,
        ST_F_T3   = 4'd3,
        ST_DECODE = 4'd4,
        ST_OP_T1  = 4'd5,
        ST_OP_T2  = 4'd6,
        ST_OP_T3  = 4'd7,
        ST_WRITE  = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    // Instruction classes recognised by the decoder.
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_HLT     = 3'd1,
        OP_MOV     = 3'd2,
        OP_MVI     = 3'd3,
        OP_JMP     = 3'd4,
        OP_ILLEGAL = 3'd5
    } op_class_e;

    // True when a register field refers to memory (M), which this
    // sequencer does not support as a MOV/MVI operand.
    function automatic logic is_mem_field(input logic [2:0] field);
        return field == REG_M;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory/register-file bus between the fetch sequencer and its datapath.
// The master side is the sequencer; the slave side is memory plus the
// register file that answer its strobes.
interface fetch_sequencer_if;

    logic        ready_i;
    logic [7:0]  data_i;
    logic        sync_o;
    logic        dbin_o;
    logic [2:0]  addr_sel_o;
    logic        pc_inc_o;
    logic        pc_load_o;
    logic [15:0] pc_addr_o;
    logic        reg_read_o;
    logic        reg_write_o;
    logic [2:0]  reg8_sel_o;
    logic        bus_drive_o;
    logic [7:0]  tmp_o;
    logic [7:0]  instr_o;
    logic        halted_o;
    logic        illegal_o;

    modport master (
        input  ready_i, data_i,
        output sync_o, dbin_o, addr_sel_o, pc_inc_o, pc_load_o, pc_addr_o,
               reg_read_o, reg_write_o, reg8_sel_o, bus_drive_o, tmp_o,
               instr_o, halted_o, illegal_o
    );

    modport slave (
        output ready_i, data_i,
        input  sync_o, dbin_o, addr_sel_o, pc_inc_o, pc_load_o, pc_addr_o,
               reg_read_o, reg_write_o, reg8_sel_o, bus_drive_o, tmp_o,
               instr_o, halted_o, illegal_o
    );

endinterface

// File: rtl/opcode_decode.sv
// Purely combinational opcode classifier. Splits the instruction register
// into its destination (bits 5:3) and source (bits 2:0) fields and decides
// which of the supported instruction shapes it is.
module opcode_decode
    import i8080_pkg::*;
(
    input  logic [7:0] instr_i,
    output op_class_e  opclass_o,
    output logic [2:0] dst_o,
    output logic [2:0] src_o
);

    logic [2:0] dst;
    logic [2:0] src;

    assign dst   = instr_i[5:3];
    assign src   = instr_i[2:0];
    assign dst_o = dst;
    assign src_o = src;

    // Classify the opcode; HLT must be tested before the MOV group since
    // 0x76 sits inside it, and any M operand falls through to ILLEGAL.
    always_comb begin
        opclass_o = OP_ILLEGAL;
        if (instr_i == OPC_NOP) begin
            opclass_o = OP_NOP;
        end else if (instr_i == OPC_HLT) begin
            opclass_o = OP_HLT;
        end else if (instr_i == OPC_JMP) begin
            opclass_o = OP_JMP;
        end else if (instr_i[7:6] == OPC_MOV_GROUP &&
                     !is_mem_field(dst) && !is_mem_field(src)) begin
            opclass_o = OP_MOV;
        end else if (instr_i[7:6] == OPC_MVI_GROUP &&
                     is_mem_field(src) && !is_mem_field(dst)) begin
            opclass_o = OP_MVI;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer for a small 8080 subset
// (NOP, HLT, MOV r,r, MVI r, JMP). Each machine cycle is split into
// T1/T2/T3 states; strobes are decoded from the current state and the
// instruction register only, so the bus value reaches nothing but the
// temp register, the instruction register and the jump target.
module fetch_sequencer
    import i8080_pkg::*;
(
    input  logic             clk50M_i,
    input  logic             rst_ni,
    fetch_sequencer_if.master bus
);

    state_e     state_q, state_d;
    logic [7:0] tmp_q, tmp_d;
    logic [7:0] instr_q, instr_d;
    logic       second_q, second_d;

    op_class_e  op_class;
    logic [2:0] dst_field;
    logic [2:0] src_field;

    logic        sync;
    logic        dbin;
    logic [2:0]  addr_sel;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_addr;
    logic        reg_read;
    logic        reg_write;
    logic [2:0]  reg8_sel;
    logic        bus_drive;
    logic        halted;
    logic        illegal;

    opcode_decode u_decode (
        .instr_i   (instr_q),
        .opclass_o (op_class),
        .dst_o     (dst_field),
        .src_o     (src_field)
    );

    // State, temp, instruction and JMP second-byte flag registers; reset
    // drops everything so no half-finished write or load can survive it.
    always_ff @(posedge clk50M_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RESET;
            tmp_q    <= 8'h00;
            instr_q  <= 8'h00;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmp_q    <= tmp_d;
            instr_q  <= instr_d;
            second_q <= second_d;
        end
    end

    // Next-state and strobe decode from the current state and instruction.
    always_comb begin
        state_d   = state_q;
        tmp_d     = tmp_q;
        instr_d   = instr_q;
        second_d  = second_q;
        sync      = 1'b0;
        dbin      = 1'b0;
        addr_sel  = 3'b000;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_addr   = 16'h0000;
        reg_read  = 1'b0;
        reg_write = 1'b0;
        reg8_sel  = 3'b000;
        bus_drive = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            ST_RESET: begin
                second_d = 1'b0;
                state_d  = ST_F_T1;
            end

            ST_F_T1: begin
                sync     = 1'b1;
                addr_sel = RP_PC;
                state_d  = ST_F_T2;
            end

            ST_F_T2: begin
                dbin     = 1'b1;
                addr_sel = RP_PC;
                if (bus.ready_i) begin
                    state_d = ST_F_T3;
                end
            end

            ST_F_T3: begin
                dbin     = 1'b1;
                addr_sel = RP_PC;
                pc_inc   = 1'b1;
                instr_d  = bus.data_i;
                state_d  = ST_DECODE;
            end

            ST_DECODE: begin
                case (op_class)
                    OP_NOP: begin
                        state_d = ST_F_T1;
                    end
                    OP_HLT: begin
                        state_d = ST_HALT;
                    end
                    OP_MOV: begin
                        reg_read = 1'b1;
                        reg8_sel = src_field;
                        tmp_d    = bus.data_i;
                        state_d  = ST_WRITE;
                    end
                    OP_MVI, OP_JMP: begin
                        second_d = 1'b0;
                        state_d  = ST_OP_T1;
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = ST_F_T1;
                    end
                endcase
            end

            ST_OP_T1: begin
                sync     = 1'b1;
                addr_sel = RP_PC;
                state_d  = ST_OP_T2;
            end

            ST_OP_T2: begin
                dbin     = 1'b1;
                addr_sel = RP_PC;
                if (bus.ready_i) begin
                    state_d = ST_OP_T3;
                end
            end

            ST_OP_T3: begin
                dbin     = 1'b1;
                addr_sel = RP_PC;
                tmp_d    = bus.data_i;
                if (op_class == OP_JMP) begin
                    if (second_q) begin
                        pc_load  = 1'b1;
                        pc_addr  = {bus.data_i, tmp_q};
                        second_d = 1'b0;
                        state_d  = ST_F_T1;
                    end else begin
                        pc_inc   = 1'b1;
                        second_d = 1'b1;
                        state_d  = ST_OP_T1;
                    end
                end else begin
                    pc_inc  = 1'b1;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                bus_drive = 1'b1;
                reg_write = 1'b1;
                reg8_sel  = dst_field;
                state_d   = ST_F_T1;
            end

            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    assign bus.sync_o      = sync;
    assign bus.dbin_o      = dbin;
    assign bus.addr_sel_o  = addr_sel;
    assign bus.pc_inc_o    = pc_inc;
    assign bus.pc_load_o   = pc_load;
    assign bus.pc_addr_o   = pc_addr;
    assign bus.reg_read_o  = reg_read;
    assign bus.reg_write_o = reg_write;
    assign bus.reg8_sel_o  = reg8_sel;
    assign bus.bus_drive_o = bus_drive;
    assign bus.tmp_o       = tmp_q;
    assign bus.instr_o     = instr_q;
    assign bus.halted_o    = halted;
    assign bus.illegal_o   = illegal;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. Each scenario task expands its
// instructions into an expected per-cycle output record, pushes it to a
// scoreboard queue together with the bus stimulus for that cycle, and
// then drains the queue cycle by cycle, comparing the DUT outputs.
module tb_fetch_sequencer;
    import i8080_pkg::*;

    typedef logic [46:0] obs_t;

    typedef struct {
        logic       ready;
        logic [7:0] data;
        obs_t       exp;
        string      tag;
    } cyc_t;

    logic clk50M_i = 1'b0;
    logic rst_ni   = 1'b0;

    cyc_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc_no = 0;
    string scen   = "";

    logic [7:0] m_tmp   = 8'h00;
    logic [7:0] m_instr = 8'h00;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk50M_i (clk50M_i),
        .rst_ni   (rst_ni),
        .bus      (bus)
    );

    // 50 MHz clock.
    always #10 clk50M_i = ~clk50M_i;

    // Global time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t pack_obs();
        return {bus.sync_o, bus.dbin_o, bus.addr_sel_o, bus.pc_inc_o,
                bus.pc_load_o, bus.pc_addr_o, bus.reg_read_o, bus.reg_write_o,
                bus.reg8_sel_o, bus.bus_drive_o, bus.tmp_o, bus.instr_o,
                bus.halted_o, bus.illegal_o};
    endfunction

    function automatic obs_t mk(input logic sync, input logic dbin,
                                input logic [2:0] asel, input logic inc,
                                input logic load, input logic [15:0] paddr,
                                input logic rr, input logic rw,
                                input logic [2:0] sel, input logic bd,
                                input logic halt, input logic ill);
        return {sync, dbin, asel, inc, load, paddr, rr, rw, sel, bd,
                m_tmp, m_instr, halt, ill};
    endfunction

    task automatic push(input logic ready, input logic [7:0] data,
                        input obs_t exp, input string phase);
        cyc_t e;
        cyc_no++;
        e.ready = ready;
        e.data  = data;
        e.exp   = exp;
        e.tag   = $sformatf("%s c%0d %s", scen, cyc_no, phase);
        sb.push_back(e);
    endtask

    task automatic exp_fetch(input logic [7:0] opc, input int waits);
        push(1'b1, 8'hEE, mk(1, 0, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "F_T1");
        for (int i = 0; i < waits; i++)
            push(1'b0, 8'hEE, mk(0, 1, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "F_T2wait");
        push(1'b1, 8'hEE, mk(0, 1, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "F_T2");
        push(1'b1, opc, mk(0, 1, RP_PC, 1, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "F_T3");
        m_instr = opc;
    endtask

    task automatic exp_decode(input logic [7:0] data, input logic rr,
                              input logic [2:0] sel, input logic ill);
        push(1'b1, data, mk(0, 0, 3'b000, 0, 0, 16'h0, rr, 0, sel, 0, 0, ill), "DECODE");
        if (rr) m_tmp = data;
    endtask

    task automatic exp_operand(input logic [7:0] byt, input int waits, input logic load);
        push(1'b1, 8'hEE, mk(1, 0, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "OP_T1");
        for (int i = 0; i < waits; i++)
            push(1'b0, 8'hEE, mk(0, 1, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "OP_T2wait");
        push(1'b1, 8'hEE, mk(0, 1, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "OP_T2");
        if (load)
            push(1'b1, byt, mk(0, 1, RP_PC, 0, 1, {byt, m_tmp}, 0, 0, 3'b000, 0, 0, 0), "OP_T3load");
        else
            push(1'b1, byt, mk(0, 1, RP_PC, 1, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "OP_T3");
        m_tmp = byt;
    endtask

    task automatic exp_write(input logic [2:0] sel);
        push(1'b1, 8'hEE, mk(0, 0, 3'b000, 0, 0, 16'h0, 0, 1, sel, 1, 0, 0), "WRITE");
    endtask

    task automatic start_scenario(input string name);
        scen   = name;
        cyc_no = 0;
        $display("[TB] scenario %s", name);
    endtask

    // Drain the scoreboard: drive each cycle's inputs after the rising
    // edge, then compare outputs just before the falling edge.
    task automatic run_queue();
        cyc_t e;
        obs_t got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk50M_i);
            #2;
            bus.ready_i = e.ready;
            bus.data_i  = e.data;
            #6;
            got = pack_obs();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got %h expected %h", e.tag, got, e.exp);
            end
        end
    endtask

    // Assert reset asynchronously, check outputs clear immediately and
    // while held, then release on a falling edge.
    task automatic pulse_reset(input string name);
        obs_t got;
        #3;
        rst_ni = 1'b0;
        #1;
        got = pack_obs();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("[TB] FAIL %s async-clear: got %h expected %h", name, got, obs_t'(0));
        end
        bus.ready_i = 1'b1;
        bus.data_i  = 8'hEE;
        @(posedge clk50M_i);
        #2;
        got = pack_obs();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("[TB] FAIL %s held-clear: got %h expected %h", name, got, obs_t'(0));
        end
        @(negedge clk50M_i);
        rst_ni  = 1'b1;
        m_tmp   = 8'h00;
        m_instr = 8'h00;
    endtask

    task automatic test_reset();
        obs_t got;
        start_scenario("reset");
        bus.ready_i = 1'b1;
        bus.data_i  = 8'h00;
        #5;
        got = pack_obs();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset-state: got %h expected %h", got, obs_t'(0));
        end
        repeat (2) @(posedge clk50M_i);
        @(negedge clk50M_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_nop();
        start_scenario("nop");
        exp_fetch(8'h00, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        exp_fetch(8'h00, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        run_queue();
    endtask

    task automatic test_mov();
        start_scenario("mov_a_b");
        exp_fetch(8'h78, 0);
        exp_decode(8'h5A, 1, REG_B, 0);
        exp_write(REG_A);
        run_queue();
    endtask

    task automatic test_mvi();
        start_scenario("mvi_a");
        exp_fetch(8'h3E, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        exp_operand(8'h99, 0, 0);
        exp_write(REG_A);
        run_queue();
    endtask

    task automatic test_jmp();
        start_scenario("jmp");
        exp_fetch(8'hC3, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        exp_operand(8'h34, 0, 0);
        exp_operand(8'h12, 3, 1);
        exp_fetch(8'h00, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        run_queue();
    endtask

    task automatic test_illegal();
        start_scenario("illegal_36");
        exp_fetch(8'h36, 0);
        exp_decode(8'hEE, 0, 3'b000, 1);
        exp_fetch(8'h00, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        run_queue();
    endtask

    task automatic test_back_to_back();
        start_scenario("back_to_back");
        exp_fetch(8'h41, 1);
        exp_decode(8'h77, 1, REG_C, 0);
        exp_write(REG_B);
        exp_fetch(8'h2E, 2);
        exp_decode(8'hEE, 0, 3'b000, 0);
        exp_operand(8'hA5, 1, 0);
        exp_write(REG_L);
        run_queue();
    endtask

    task automatic test_halt();
        start_scenario("halt");
        exp_fetch(8'h76, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        for (int i = 0; i < 20; i++)
            push(1'($urandom_range(1)), 8'($urandom_range(255)),
                 mk(0, 0, 3'b000, 0, 0, 16'h0, 0, 0, 3'b000, 0, 1, 0), "HALT");
        run_queue();
        pulse_reset("halt_reset");
        start_scenario("after_halt");
        exp_fetch(8'h00, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        run_queue();
    endtask

    task automatic test_reset_mid_jmp();
        start_scenario("jmp_abort");
        exp_fetch(8'hC3, 0);
        exp_decode(8'hEE, 0, 3'b000, 0);
        exp_operand(8'h34, 0, 0);
        push(1'b1, 8'hEE, mk(1, 0, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "OP_T1");
        push(1'b0, 8'h12, mk(0, 1, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "OP_T2wait");
        push(1'b0, 8'h12, mk(0, 1, RP_PC, 0, 0, 16'h0, 0, 0, 3'b000, 0, 0, 0), "OP_T2wait");
        run_queue();
        pulse_reset("jmp_reset");
        start_scenario("after_jmp_abort");
        exp_fetch(8'h78, 0);
        exp_decode(8'h3C, 1, REG_B, 0);
        exp_write(REG_A);
        run_queue();
    endtask

    initial begin
        bus.ready_i = 1'b1;
        bus.data_i  = 8'h00;
        test_reset();
        test_nop();
        test_mov();
        test_mvi();
        test_jmp();
        test_illegal();
        test_back_to_back();
        test_halt();
        test_reset_mid_jmp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk50M_i and rst_ni.
REQ-002 clk50M_i  input  1  system clock; all state changes occur on its rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 ready_i  input  1  memory ready; sampled in T2.
REQ-005 data_i  input  8  data bus value read from memory or a register.
REQ-006 sync_o  output  1  high during every T1.
REQ-007 dbin_o  output  1  high during T2 and T3 of memory-read cycles.
REQ-008 addr_sel_o  output  3  address-latch source: PC=3'b100 in all fetch and operand cycles.
REQ-009 pc_inc_o  output  1  one-cycle program-counter increment pulse.
REQ-010 pc_load_o  output  1  one-cycle program-counter load pulse.
REQ-011 pc_addr_o  output  16  jump target; valid while pc_load_o is high.
REQ-012 reg_read_o  output  1  selected register drives data bus.
REQ-013 reg_write_o  output  1  selected register captures data bus.
REQ-014 reg8_sel_o  output  3  register code: B=000, C=001, D=010, E=011, H=100, L=101, A=111.
REQ-015 bus_drive_o  output  1  tmp_o drives data bus.
REQ-016 tmp_o  output  8  internal temp register.
REQ-017 instr_o  output  8  current instruction register.
REQ-018 halted_o  output  1  high while in HALT.
REQ-019 illegal_o  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-020 The states SHALL be RESET, F_T1, F_T2, F_T3, DECODE, OP_T1, OP_T2, OP_T3, WRITE and HALT.
- RESET->F_T1 on the first edge after reset release.
REQ-021 Fetch behaviour:
- F_T1: sync_o=1.
- F_T2: dbin_o=1; stays in F_T2 while ready_i=0.
- F_T3: dbin_o=1; instr_o<=data_i; pc_inc_o=1.
REQ-022 DECODE behaviour by opcode:
- 0x00 NOP -> F_T1 (4 cycles total).
- 0x76 HLT -> HALT.
- 0x40-0x7F with neither register field equal to 110 (MOV d,s): reg_read_o=1, reg8_sel_o=s, tmp<=data_i -> WRITE (5 cycles).
- 00ddd110 with ddd not 110 (MVI d): -> OP_T1.
- 0xC3 JMP: -> OP_T1.
REQ-023 Operand read OP_T1/OP_T2/OP_T3 SHALL mirror F_T1/F_T2/F_T3 (sync, dbin, wait on ready_i=0, pc_inc_o in OP_T3), capturing data_i into tmp in OP_T3.
REQ-024 MVI SHALL perform one operand read and then go to WRITE (8 cycles total).
REQ-025 JMP SHALL perform two operand reads.
- First read: low byte into tmp.
- Second OP_T3: pc_inc_o=0, pc_load_o=1, pc_addr_o={data_i,tmp} -> F_T1 (10 cycles total).
REQ-026 WRITE behaviour:
- bus_drive_o=1, reg_write_o=1, reg8_sel_o=d -> F_T1.
- reg_read_o and bus_drive_o SHALL never be high together.
REQ-027 Any other opcode SHALL pulse illegal_o in DECODE and be executed as NOP.
REQ-028 HALT SHALL be exited only by reset; all strobes stay low and halted_o=1.
REQ-029 pc_inc_o and pc_load_o SHALL never be high together.
REQ-030 Strobe outputs SHALL be decoded from the current state and instr_o only; data_i SHALL feed only tmp, instr_o and pc_addr_o.

Reset
REQ-031 Asserting rst_ni low SHALL immediately force state RESET and clear every output, including tmp_o, instr_o and pc_addr_o, to 0, including mid-instruction or during a wait state.
REQ-032 No pending write or PC load SHALL complete after a reset.

Structure
REQ-033 A shared package i8080_pkg SHALL hold the register codes, the 16-bit select codes (BC=000, DE=001, HL=010, SP=011, PC=100), the state enum and the opcode constants.
REQ-034 A combinational sub-module opcode_decode SHALL classify instr_o into NOP/HLT/MOV/MVI/JMP/ILLEGAL and extract the d and s fields.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset released, ready_i=1, data_i=0x00 -> sync_o at cycles 1 and 5, pc_inc_o at cycles 3 and 7.
- Opcode 0x78 (MOV A,B), data_i=0x5A during DECODE -> reg_read_o sel=000, then WRITE with sel=111, tmp_o=0x5A.
- Opcode 0x3E then operand 0x99 -> two pc_inc_o pulses, WRITE sel=111, tmp_o=0x99, 8 cycles.
- Opcode 0xC3, bytes 0x34 and 0x12 -> pc_load_o with pc_addr_o=0x1234 in cycle 10; ready_i=0 for 3 cycles in OP_T2 -> 13 cycles.
- Opcode 0x76 -> halted_o=1 and no strobes for 20 cycles; rst_ni pulsed mid-HALT and mid-JMP -> all outputs 0, restart at F_T1.
- Opcode 0x36 -> illegal_o pulse, executed as 4-cycle NOP.
